// File: rtl/csc_row_gen.sv
`default_nettype none
// ============================================================================
// Module   : csc_row_gen
// Purpose  : Forms one sparse row from a complex scale s and NUM_TAP complex
//            taps a_k at columns z_k. Each tap yields s*a_k at z_k and
//            +/-s*a_k at (z_k + MAT_RANK/2) mod MAT_RANK. Coincident columns
//            are summed at full precision, then shifted by FRAC and saturated.
//            Entries are streamed one per beat in ascending column order.
// Ports    : clk, rst (async, active-high)
//            in_vld/in_rdy, s_re/s_im, a_re/a_im (tap k at [k*DW +: DW]),
//            z (tap k at [k*IDX_W +: IDX_W]), neg_half : input bundle
//            out_vld/out_rdy, out_idx, out_re/out_im, out_last : entry stream
//            busy : high whenever a row is in flight
// Revision : 1.0 - initial release
// ============================================================================
module csc_row_gen #(
  parameter int MAT_RANK = 256,
  parameter int DW       = 32,
  parameter int FRAC     = 17,
  parameter int NUM_TAP  = 2,
  localparam int IDX_W   = $clog2(MAT_RANK)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic [DW-1:0]            s_re,
  input  logic [DW-1:0]            s_im,
  input  logic [NUM_TAP*DW-1:0]    a_re,
  input  logic [NUM_TAP*DW-1:0]    a_im,
  input  logic [NUM_TAP*IDX_W-1:0] z,
  input  logic                     neg_half,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [IDX_W-1:0]         out_idx,
  output logic [DW-1:0]            out_re,
  output logic [DW-1:0]            out_im,
  output logic                     out_last,
  output logic                     busy
);

  localparam int NE = 2 * NUM_TAP;            // sparse entries per row
  localparam int PW = 2 * DW + 1;             // full-precision product width
  localparam int SW = PW + $clog2(NE) + 1;    // merge-sum width, no overflow
  localparam logic [IDX_W-1:0] HALF = {1'b1, {(IDX_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, EMIT = 2'd2} state_t;

  state_t                   state_q, state_d;
  logic [DW-1:0]            s_re_q, s_im_q;
  logic [NUM_TAP*DW-1:0]    a_re_q, a_im_q;
  logic [NUM_TAP*IDX_W-1:0] z_q;
  logic                     neg_q;
  logic [IDX_W-1:0]         ent_idx_q [NE];
  logic signed [PW-1:0]     ent_re_q  [NE];
  logic signed [PW-1:0]     ent_im_q  [NE];
  logic [NE-1:0]            cons_q;

  logic signed [PW-1:0]     w_p_re [NUM_TAP];
  logic signed [PW-1:0]     w_p_im [NUM_TAP];

  // Complex multiply per tap; each partial product is sign-extended by one
  // bit so the sum/difference cannot overflow.
  for (genvar k = 0; k < NUM_TAP; k++) begin : g_tap
    logic signed [2*DW-1:0] w_rr, w_ii, w_ri, w_ir;
    assign w_rr = $signed(a_re_q[k*DW +: DW]) * $signed(s_re_q);
    assign w_ii = $signed(a_im_q[k*DW +: DW]) * $signed(s_im_q);
    assign w_ri = $signed(a_re_q[k*DW +: DW]) * $signed(s_im_q);
    assign w_ir = $signed(a_im_q[k*DW +: DW]) * $signed(s_re_q);
    assign w_p_re[k] = {w_rr[2*DW-1], w_rr} - {w_ii[2*DW-1], w_ii};
    assign w_p_im[k] = {w_ri[2*DW-1], w_ri} + {w_ir[2*DW-1], w_ir};
  end

  function automatic logic [DW-1:0] sat(input logic signed [SW-1:0] v);
    logic [SW-DW:0] top;
    top = v[SW-1:DW-1];
    if ((&top) || !(|top)) return v[DW-1:0];
    return v[SW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  endfunction

  // Minimum unconsumed column, its merged sum, and whether other columns remain.
  logic [IDX_W-1:0]     w_m;
  logic [NE-1:0]        w_hit;
  logic                 w_other;
  logic                 w_found;
  logic signed [SW-1:0] w_sum_re, w_sum_im;

  always_comb begin
    w_m      = '0;
    w_found  = 1'b0;
    w_hit    = '0;
    w_other  = 1'b0;
    w_sum_re = '0;
    w_sum_im = '0;
    for (int i = 0; i < NE; i++) begin
      if (!cons_q[i] && (!w_found || ent_idx_q[i] < w_m)) begin
        w_m     = ent_idx_q[i];
        w_found = 1'b1;
      end
    end
    for (int i = 0; i < NE; i++) begin
      if (!cons_q[i]) begin
        if (ent_idx_q[i] == w_m) begin
          w_hit[i] = 1'b1;
          w_sum_re = w_sum_re + {{(SW-PW){ent_re_q[i][PW-1]}}, ent_re_q[i]};
          w_sum_im = w_sum_im + {{(SW-PW){ent_im_q[i][PW-1]}}, ent_im_q[i]};
        end else begin
          w_other = 1'b1;
        end
      end
    end
  end

  logic signed [SW-1:0] w_sh_re, w_sh_im;
  assign w_sh_re = w_sum_re >>> FRAC;
  assign w_sh_im = w_sum_im >>> FRAC;

  // Next-state and outputs. Outputs derive only from registered entries and
  // the consumed mask, so they hold stable under backpressure.
  always_comb begin
    state_d  = state_q;
    in_rdy   = 1'b0;
    busy     = 1'b1;
    out_vld  = 1'b0;
    out_idx  = '0;
    out_re   = '0;
    out_im   = '0;
    out_last = 1'b0;
    case (state_q)
      IDLE: begin
        in_rdy = 1'b1;
        busy   = 1'b0;
        if (in_vld) state_d = MUL;
      end
      MUL:  state_d = EMIT;
      EMIT: begin
        out_vld  = 1'b1;
        out_idx  = w_m;
        out_re   = sat(w_sh_re);
        out_im   = sat(w_sh_im);
        out_last = !w_other;
        if (out_rdy && !w_other) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_re_q  <= '0;
      s_im_q  <= '0;
      a_re_q  <= '0;
      a_im_q  <= '0;
      z_q     <= '0;
      neg_q   <= 1'b0;
      cons_q  <= '0;
      for (int i = 0; i < NE; i++) begin
        ent_idx_q[i] <= '0;
        ent_re_q[i]  <= '0;
        ent_im_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (in_vld) begin
          s_re_q <= s_re;
          s_im_q <= s_im;
          a_re_q <= a_re;
          a_im_q <= a_im;
          z_q    <= z;
          neg_q  <= neg_half;
        end
        MUL: begin
          for (int k = 0; k < NUM_TAP; k++) begin
            ent_idx_q[2*k]   <= z_q[k*IDX_W +: IDX_W];
            ent_re_q[2*k]    <= w_p_re[k];
            ent_im_q[2*k]    <= w_p_im[k];
            // Index addition wraps naturally at IDX_W bits.
            ent_idx_q[2*k+1] <= z_q[k*IDX_W +: IDX_W] + HALF;
            ent_re_q[2*k+1]  <= neg_q ? -w_p_re[k] : w_p_re[k];
            ent_im_q[2*k+1]  <= neg_q ? -w_p_im[k] : w_p_im[k];
          end
          cons_q <= '0;
        end
        EMIT: if (out_rdy) cons_q <= cons_q | w_hit;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_csc_row_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_csc_row_gen
// Purpose  : Directed self-checking bench for csc_row_gen with default
//            parameters (MAT_RANK=256, DW=32, FRAC=17, NUM_TAP=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_csc_row_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic [31:0] s_re = '0, s_im = '0;
  logic [63:0] a_re = '0, a_im = '0;
  logic [15:0] z = '0;
  logic        neg_half = 1'b0;
  logic        out_vld;
  logic        out_rdy = 1'b1;
  logic [7:0]  out_idx;
  logic [31:0] out_re, out_im;
  logic        out_last;
  logic        busy;

  csc_row_gen dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy),
    .s_re(s_re), .s_im(s_im), .a_re(a_re), .a_im(a_im), .z(z),
    .neg_half(neg_half), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_idx(out_idx), .out_re(out_re), .out_im(out_im),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  e_idx [8];
  logic [31:0] e_re  [8];
  logic [31:0] e_im  [8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_exp(input int b, input int idx, input int re, input int im);
    e_idx[b] = 8'(idx);
    e_re[b]  = 32'(re);
    e_im[b]  = 32'(im);
  endtask

  // Presents a bundle, checks the MUL cycle, and returns at the first EMIT cycle.
  task automatic send(input logic [31:0] sre, input logic [31:0] sim,
                      input logic [31:0] a0r, input logic [31:0] a0i, input logic [7:0] z0,
                      input logic [31:0] a1r, input logic [31:0] a1i, input logic [7:0] z1,
                      input logic neg);
    int t;
    t = 0;
    @(negedge clk);
    s_re = sre; s_im = sim;
    a_re = {a1r, a0r}; a_im = {a1i, a0i};
    z = {z1, z0}; neg_half = neg; in_vld = 1'b1;
    while (!in_rdy && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("in_rdy_wait", 32'(in_rdy), 32'd1);
    @(negedge clk);
    in_vld = 1'b0;
    chk("mul_vld", 32'(out_vld), 32'd0);
    chk("mul_in_rdy", 32'(in_rdy), 32'd0);
    chk("mul_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("first_vld", 32'(out_vld), 32'd1);
  endtask

  task automatic expect_row(input int n, input int stall_beat, input int stall_cyc,
                            input int abort_beat);
    for (int b = 0; b < n; b++) begin
      if (b == abort_beat) begin
        rst = 1'b1;
        #1;
        chk("rst_vld", 32'(out_vld), 32'd0);
        chk("rst_in_rdy", 32'(in_rdy), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (b == stall_beat) begin
        out_rdy = 1'b0;
        for (int c = 0; c < stall_cyc; c++) begin
          @(negedge clk);
          chk("bp_vld", 32'(out_vld), 32'd1);
          chk("bp_idx", 32'(out_idx), 32'(e_idx[b]));
          chk("bp_re", out_re, e_re[b]);
          chk("bp_im", out_im, e_im[b]);
          chk("bp_in_rdy", 32'(in_rdy), 32'd0);
        end
        out_rdy = 1'b1;
      end
      chk("beat_vld", 32'(out_vld), 32'd1);
      chk("beat_idx", 32'(out_idx), 32'(e_idx[b]));
      chk("beat_re", out_re, e_re[b]);
      chk("beat_im", out_im, e_im[b]);
      chk("beat_last", 32'(out_last), (b == n - 1) ? 32'd1 : 32'd0);
      chk("beat_in_rdy", 32'(in_rdy), 32'd0);
      @(negedge clk);
    end
    chk("end_vld", 32'(out_vld), 32'd0);
    chk("end_in_rdy", 32'(in_rdy), 32'd1);
  endtask

  task automatic exp_test1();
    set_exp(0, 3, 0, 131072);
    set_exp(1, 5, 262144, 0);
    set_exp(2, 131, 0, -131072);
    set_exp(3, 133, -262144, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_rdy0", 32'(in_rdy), 32'd1);
    chk("rst_vld0", 32'(out_vld), 32'd0);
    chk("rst_busy0", 32'(busy), 32'd0);
    chk("rst_idx0", 32'(out_idx), 32'd0);
    chk("rst_re0", out_re, 32'd0);
    chk("rst_im0", out_im, 32'd0);
    chk("rst_last0", 32'(out_last), 32'd0);
    rst = 1'b0;

    // Four distinct columns.
    exp_test1();
    send(32'd131072, 32'd0, 32'd262144, 32'd0, 8'd5, 32'd0, 32'd131072, 8'd3, 1'b1);
    expect_row(4, -1, 0, -1);

    // Equal z: taps merge at 7 and at 135.
    set_exp(0, 7, 262144, 131072);
    set_exp(1, 135, -262144, -131072);
    send(32'd131072, 32'd0, 32'd262144, 32'd0, 8'd7, 32'd0, 32'd131072, 8'd7, 1'b1);
    expect_row(2, -1, 0, -1);
    set_exp(1, 135, 262144, 131072);
    send(32'd131072, 32'd0, 32'd262144, 32'd0, 8'd7, 32'd0, 32'd131072, 8'd7, 1'b0);
    expect_row(2, -1, 0, -1);

    // Wrap-around of the upper-half index.
    set_exp(0, 10, 0, 131072);
    set_exp(1, 72, -262144, 0);
    set_exp(2, 138, 0, -131072);
    set_exp(3, 200, 262144, 0);
    send(32'd131072, 32'd0, 32'd262144, 32'd0, 8'd200, 32'd0, 32'd131072, 8'd10, 1'b1);
    expect_row(4, -1, 0, -1);

    // Saturation both directions; zero tap still emitted.
    set_exp(0, 0, 32'h7FFFFFFF, 0);
    set_exp(1, 1, 0, 0);
    set_exp(2, 128, 32'h80000000, 0);
    set_exp(3, 129, 0, 0);
    send(32'h7FFFFFFF, 32'd0, 32'h7FFFFFFF, 32'd0, 8'd0, 32'd0, 32'd0, 8'd1, 1'b1);
    expect_row(4, -1, 0, -1);

    // Cross-tap collision with cancellation to zero.
    set_exp(0, 5, 0, 0);
    set_exp(1, 133, 0, 0);
    send(32'd131072, 32'd0, 32'd262144, 32'd0, 8'd5, 32'd262144, 32'd0, 8'd133, 1'b1);
    expect_row(2, -1, 0, -1);

    // Backpressure on beat 2 for three cycles.
    exp_test1();
    send(32'd131072, 32'd0, 32'd262144, 32'd0, 8'd5, 32'd0, 32'd131072, 8'd3, 1'b1);
    expect_row(4, 1, 3, -1);

    // Reset during beat 2, then a clean full row.
    send(32'd131072, 32'd0, 32'd262144, 32'd0, 8'd5, 32'd0, 32'd131072, 8'd3, 1'b1);
    expect_row(4, -1, 0, 1);
    chk("post_rst_vld", 32'(out_vld), 32'd0);
    send(32'd131072, 32'd0, 32'd262144, 32'd0, 8'd5, 32'd0, 32'd131072, 8'd3, 1'b1);
    expect_row(4, -1, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/csc_row_gen.md
Name: csc_row_gen

Overview:
- Parametrised successor to the fixed two-tap, four-entry row-vector store.
- Takes a complex scale factor s and NUM_TAP complex coefficients a_k at column positions z_k.
- Forms 2*NUM_TAP sparse entries: s*a_k at z_k, and ±s*a_k at (z_k + MAT_RANK/2) mod MAT_RANK.
- Merges entries that share a column and streams the result, one entry per beat in ascending column order, to the downstream CSC matrix builder.

Parameters:
MAT_RANK, 256, matrix rank N; power of two, >= 4; IDX_W = clog2(MAT_RANK)
DW, 32, signed two's-complement width of every real/imag value
FRAC, 17, fixed-point fraction bits; products are arithmetically shifted right by FRAC
NUM_TAP, 2, number of input coefficient taps, 1..8

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset; one clock; reset is asynchronous and active-high
in_vld  in  1  input bundle valid
in_rdy  out  1  block idle and able to accept a bundle
s_re / s_im  in  DW each  scale factor s
a_re / a_im  in  NUM_TAP*DW each  tap k occupies bits [k*DW +: DW]
z  in  NUM_TAP*IDX_W  tap k column, bits [k*IDX_W +: IDX_W]
neg_half  in  1  1: upper-half entries are -s*a_k; 0: +s*a_k
out_vld  out  1  output entry valid
out_rdy  in  1  downstream accepts the entry
out_idx  out  IDX_W  column of the entry
out_re / out_im  out  DW each  entry value
out_last  out  1  final entry of the row
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst=1): state IDLE, in_rdy=1, out_vld=0, out_last=0, out_idx/out_re/out_im=0, busy=0, entry array and consumed mask cleared. Reset mid-operation discards the row; no partial beats follow.
- FSM states: IDLE, MUL, EMIT.
- IDLE:
  - in_rdy=1.
  - On in_vld & in_rdy, register s, a, z and neg_half, then go to MUL.
  - in_rdy is registered and drops the cycle after the handshake.
- MUL (exactly 1 cycle):
  - For each k: p_re = a_re*s_re - a_im*s_im; p_im = a_re*s_im + a_im*s_re.
  - Full precision is 2*DW+1 bits, signed.
  - Entry 2k gets (z_k, p). Entry 2k+1 gets ((z_k + MAT_RANK/2) mod MAT_RANK, neg_half ? -p : p), with the index wrapping modulo MAT_RANK.
  - All entries are marked unconsumed. Go to EMIT with out_vld=1 the following cycle.
- EMIT:
  - m = minimum index over unconsumed entries.
  - Output value = full-precision sum of all unconsumed entries with index m, then >>> FRAC, then saturated to the DW signed range.
  - out_idx = m. out_last = 1 iff no unconsumed entry has index != m.
- Handshake:
  - On out_vld & out_rdy, every entry with index m is marked consumed.
  - If out_last, go to IDLE: out_vld=0 and in_rdy=1 the next cycle. Otherwise the next unique index is presented the next cycle.
- Backpressure: with out_vld=1 and out_rdy=0, out_idx, out_re, out_im and out_last hold stable. out_vld never drops without a handshake.
- Latency: input handshake at cycle T gives first out_vld at T+2. Unique columns U (1..2*NUM_TAP) are emitted in U beats at full throughput. The next in_rdy is asserted the cycle after the last beat.
- Merging: entries sum before shift and saturation, so coincident columns incur no double rounding. Values that cancel to zero are still emitted.
- Equal z values across taps, or a z_k colliding with another tap's wrapped index, merge identically.
- in_vld while busy is ignored; the source must hold it.

Test Plan:
- Q.17 defaults; s=(131072,0); a0=(262144,0), z0=5; a1=(0,131072), z1=3; neg_half=1 -> beats (3,0,131072), (5,262144,0), (131,0,-131072), (133,-262144,0) with last on beat 4; first out_vld 2 cycles after handshake.
- Same stimulus with z0=z1=7 -> 2 beats: (7,262144,131072), (135,-262144,-131072), last on beat 2; neg_half=0 gives second beat (135,262144,131072).
- Wrap-around: z0=200, z1=10, a as in test 1 -> order 10, 72, 138, 200; column 72 value (-262144,0).
- Saturation: s=(0x7FFFFFFF,0), a0=(0x7FFFFFFF,0) -> beats for that tap show out_re=0x7FFFFFFF (upper half with neg_half=1: 0x80000000); out_im=0.
- Backpressure: out_rdy low 3 cycles on beat 2 -> outputs frozen, no beat lost or duplicated; in_rdy stays 0 until the cycle after last.
- Assert rst during EMIT beat 2 -> out_vld=0 and in_rdy=1 immediately; a following bundle produces a clean full row.
